// File: rtl/instruction_fetch.sv
// LEGv8 instruction-fetch stage: PC, ROM addressing and the IF/ID register.
// Handles decode stalls, branch redirects with a one-bubble flush, and end of program.
module instruction_fetch #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PROG_LEN  = 7,
    parameter logic [31:0]       NOP_INSTR = 32'hD503201F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              done,
    output logic [15:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(PROG_LEN);

    logic [ADDR_W-1:0] pc;
    logic              in_prog;

    assign rom_addr = pc;
    assign in_prog  = (pc < END_PC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            done        <= 1'b0;
            fetch_count <= 16'd0;
        end else if (branch_taken) begin
            // Redirect beats stall and done; the in-flight slot becomes a bubble.
            pc          <= branch_target;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            done        <= 1'b0;
        end else if (!stall) begin
            if (in_prog) begin
                if_id_instr <= rom_data;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                pc          <= pc + 1'b1;
                if (fetch_count != 16'hFFFF)
                    fetch_count <= fetch_count + 16'd1;
            end else begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small combinational ROM.
// Expected results are queued per step and popped after each clock edge.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'hD503201F;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
        logic        valid;
        logic        done;
        logic [15:0] cnt;
        logic [15:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'd0;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        done;
    logic [15:0] fetch_count;

    logic [31:0] rom [0:6];
    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign rom_data = (rom_addr < 16'd7) ? rom[rom_addr[2:0]] : 32'hDEADBEEF;

    instruction_fetch dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid),
        .done(done),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".instr"}, if_id_instr, e.instr);
        chk({tag, ".pc"}, {16'd0, if_id_pc}, {16'd0, e.pc});
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e.done});
        chk({tag, ".cnt"}, {16'd0, fetch_count}, {16'd0, e.cnt});
        chk({tag, ".addr"}, {16'd0, rom_addr}, {16'd0, e.addr});
    endtask

    // Drive one cycle of inputs, queue the expectation, check after the edge.
    task automatic step(input string tag, input logic st, input logic br,
                        input logic [15:0] tgt, input logic [31:0] ei,
                        input logic [15:0] ep, input logic ev,
                        input logic ed, input logic [15:0] ec,
                        input logic [15:0] ea);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        sb.push_back('{ei, ep, ev, ed, ec, ea});
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rom[0] = 32'hF84000A1;
        rom[1] = 32'hF84010A2;
        rom[2] = 32'h8B010043;
        rom[3] = 32'hCB020064;
        rom[4] = 32'h8A030085;
        rom[5] = 32'hAA0300A6;
        rom[6] = 32'hF80020A4;

        // Reset state
        #12;
        sb.push_back('{NOP, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0});
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free run through the program
        for (int k = 0; k < 7; k++)
            step($sformatf("run%0d", k), 1'b0, 1'b0, 16'd0, rom[k],
                 16'(k), 1'b1, 1'b0, 16'(k + 1), 16'(k + 1));
        step("end", 0, 0, 0, NOP, 16'd6, 0, 1, 16'd7, 16'd7);
        step("end_stall", 1, 0, 0, NOP, 16'd6, 0, 1, 16'd7, 16'd7);
        step("end_hold", 0, 0, 0, NOP, 16'd6, 0, 1, 16'd7, 16'd7);

        // Redirect out of done back to word 3
        step("br3", 0, 1, 16'd3, NOP, 16'd6, 0, 0, 16'd7, 16'd3);
        step("br3_sub", 0, 0, 0, 32'hCB020064, 16'd3, 1, 0, 16'd8, 16'd4);
        step("w4", 0, 0, 0, rom[4], 16'd4, 1, 0, 16'd9, 16'd5);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{NOP, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0});
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        step("r0", 0, 0, 0, rom[0], 16'd0, 1, 0, 16'd1, 16'd1);
        step("r1", 0, 0, 0, rom[1], 16'd1, 1, 0, 16'd2, 16'd2);

        // Stall three cycles at pc = 2
        for (int k = 0; k < 3; k++)
            step($sformatf("stall%0d", k), 1'b1, 1'b0, 16'd0,
                 32'hF84010A2, 16'd1, 1'b1, 1'b0, 16'd2, 16'd2);
        step("unstall", 0, 0, 0, 32'h8B010043, 16'd2, 1, 0, 16'd3, 16'd3);
        step("r3", 0, 0, 0, rom[3], 16'd3, 1, 0, 16'd4, 16'd4);

        // Branch to 0 at pc = 4
        step("br0", 0, 1, 16'd0, NOP, 16'd3, 0, 0, 16'd4, 16'd0);
        step("br0_tgt", 0, 0, 0, 32'hF84000A1, 16'd0, 1, 0, 16'd5, 16'd1);
        step("b1", 0, 0, 0, rom[1], 16'd1, 1, 0, 16'd6, 16'd2);
        step("b2", 0, 0, 0, rom[2], 16'd2, 1, 0, 16'd7, 16'd3);

        // Branch and stall together: redirect wins
        step("brst5", 1, 1, 16'd5, NOP, 16'd2, 0, 0, 16'd7, 16'd5);
        step("orr", 0, 0, 0, 32'hAA0300A6, 16'd5, 1, 0, 16'd8, 16'd6);
        step("w6", 0, 0, 0, rom[6], 16'd6, 1, 0, 16'd9, 16'd7);
        step("done2", 0, 0, 0, NOP, 16'd6, 0, 1, 16'd9, 16'd7);

        // Redirect past the end of the program
        step("br10", 0, 1, 16'd10, NOP, 16'd6, 0, 0, 16'd9, 16'd10);
        step("br10_done", 0, 0, 0, NOP, 16'd6, 0, 1, 16'd9, 16'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Instruction-fetch (IF) stage of the pipelined LEGv8 processor. Holds the program counter and drives the word address into the combinational instruction ROM. Registers the returned 32-bit instruction and its PC into the IF/ID pipeline register. Handles decode-stage stalls, branch redirects with flush, and end-of-program detection.

Parameters:
ADDR_W, 16, width of the PC and ROM word address.
RESET_PC, 16'h0000, PC value loaded on reset.
PROG_LEN, 7, number of valid ROM words; legal range is 1 to 2^ADDR_W-1.
NOP_INSTR, 32'hD503201F, bubble encoding inserted on flush or past end of program.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit holds IF (PC and IF/ID register frozen)
branch_taken  in  1  redirect request from the execute stage
branch_target  in  ADDR_W  word address to redirect to
rom_addr  out  ADDR_W  address to instruction ROM; combinational, equals pc
rom_data  in  32  instruction from ROM, valid in the same cycle as rom_addr
if_id_instr  out  32  registered instruction to decode
if_id_pc  out  ADDR_W  registered PC of if_id_instr
if_id_valid  out  1  if_id_instr is a real fetched instruction (0 = bubble)
done  out  1  PC has reached or passed PROG_LEN; fetch is idle
fetch_count  out  16  number of valid instructions issued; saturating

Behaviour:
- Reset (asynchronous assert, any time including mid-stall or mid-redirect):
  - pc = RESET_PC
  - if_id_instr = NOP_INSTR, if_id_pc = 0, if_id_valid = 0
  - done = 0, fetch_count = 0
  - Release is synchronous to clk. The first fetch happens on the first rising edge after release.
- rom_addr = pc at all times. The ROM is combinational, so there are no ROM wait states.
- Per rising edge, the first matching case applies:
  1. branch_taken = 1:
     - pc <= branch_target
     - if_id_instr <= NOP_INSTR, if_id_valid <= 0; if_id_pc holds
     - done <= 0
     - A redirect wins over stall and over done.
  2. stall = 1: pc, if_id_*, done and fetch_count all hold.
  3. pc < PROG_LEN:
     - if_id_instr <= rom_data, if_id_pc <= pc, if_id_valid <= 1
     - pc <= pc + 1
     - fetch_count <= fetch_count + 1, saturating at 16'hFFFF
  4. pc >= PROG_LEN:
     - if_id_instr <= NOP_INSTR, if_id_valid <= 0
     - pc holds, done <= 1
- Latency:
  - The instruction at address A appears on if_id_instr one edge after pc = A.
  - A redirect costs exactly one bubble cycle, then the target instruction follows on the next edge.
- Width rule: pc + 1 is computed modulo 2^ADDR_W. Wrap cannot occur for legal PROG_LEN because fetch stops at PROG_LEN.
- Redirect boundaries:
  - branch_target >= PROG_LEN: pc loads it, and done asserts on the following edge.
  - Redirect to a target below PROG_LEN while done = 1: done clears and fetch resumes.
- Stall during done: everything holds; done stays 1.
- fetch_count counts only cycles where if_id_valid is loaded with 1. Bubbles and stalls do not count.

Test Plan:
- Reset, then 7 free-running edges:
  - if_id_instr sequence is F84000A1, F84010A2, 8B010043, ... through STUR F80020A4
  - if_id_pc runs 0..6, valid = 1 throughout
  - Edge 8: valid = 0, instr = D503201F, done = 1, fetch_count = 7
- Stall held high for 3 cycles while pc = 2: if_id_instr stays F84010A2 (pc 1) and pc stays 2. On release, 8B010043 issues with if_id_pc = 2.
- branch_taken with target 0 at pc = 4:
  - Next edge: bubble (valid = 0, NOP)
  - Edge after: F84000A1 with if_id_pc = 0
  - fetch_count does not increment on the bubble
- branch_taken and stall asserted together with target 5: redirect wins, pc = 5, bubble issued. The following edge issues the ORR at address 5.
- Reach done = 1, then branch to 3: done clears on that edge, and the next edge issues word 3 (SUB, CB020064).
- Assert rst_n low asynchronously mid-stream between edges: outputs go to reset values immediately, without a clock. After release, fetch restarts at pc = 0.
